next_pc_unit: RTL and testbench

Parametrised successor to the processor's branch-target adder: a registered program counter with target generation, conditional branch resolution, stall, and a small return-address stack (RAS) for call/return. Sits at the front of the single-cycle datapath. Drives instruction memory with `PC`. Takes its branch mode from the control unit and the zero flag from the ALU.

---
 rtl/pc_pkg.sv | 13 +
 rtl/return_stack.sv | 59 +++++
 rtl/next_pc_unit.sv | 80 ++++++++
 tb/tb_next_pc_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Branch-mode encodings shared by the control unit and the next-PC logic.
package pc_pkg;
    localparam int BR_W = 3;

    typedef enum logic [BR_W-1:0] {
        BR_SEQ  = 3'd0,
        BR_JUMP = 3'd1,
        BR_BEQ  = 3'd2,
        BR_BNE  = 3'd3,
        BR_CALL = 3'd4,
        BR_RET  = 3'd5
    } br_mode_t;
endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_stack #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] cnt;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_MAX);
    assign ptr_inc = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? PTR_MAX : ptr - 1'b1;
    assign do_pop  = pop && !push && !empty;
    assign top     = mem[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push && full;
            underflow <= pop && !push && empty;
            if (push) begin
                ptr <= ptr_inc;
                if (!full) cnt <= cnt + 1'b1;
            end else if (do_pop) begin
                ptr <= ptr_dec;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Entries are not reset; count and pointer alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[ptr_inc] <= push_data;
    end
endmodule

// File: rtl/next_pc_unit.sv
// Registered program counter with target adder, branch resolution,
// stall and a return-address stack for call/return.
module next_pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              OFF_W     = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic [BR_W-1:0]  BR_MODE,
    input  logic             ZERO,
    input  logic [OFF_W-1:0] OFFSET,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PC_PLUS4,
    output logic [PC_W-1:0]  TARGET,
    output logic             RAS_EMPTY,
    output logic             RAS_FULL,
    output logic             RAS_OVF,
    output logic             RAS_UNF
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] ras_top;
    logic            take_tgt;
    logic            take_ret;
    logic            push;
    logic            pop;

    assign off_ext  = {{(PC_W-OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
    assign PC_PLUS4 = pc_q + PC_W'(4);
    assign TARGET   = PC_PLUS4 + (off_ext << 2);
    assign PC       = pc_q;

    assign take_tgt = (BR_MODE == BR_JUMP)
                   || (BR_MODE == BR_CALL)
                   || ((BR_MODE == BR_BEQ) && ZERO)
                   || ((BR_MODE == BR_BNE) && !ZERO);
    // An empty-stack return falls through to the next instruction.
    assign take_ret = (BR_MODE == BR_RET) && !RAS_EMPTY;
    assign push     = !STALL && (BR_MODE == BR_CALL);
    assign pop      = !STALL && (BR_MODE == BR_RET);

    always_comb begin
        pc_d = PC_PLUS4;
        unique case (1'b1)
            take_ret: pc_d = ras_top;
            take_tgt: pc_d = TARGET;
            default:  pc_d = PC_PLUS4;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= RESET_PC;
        end else if (!STALL) begin
            pc_q <= pc_d;
        end
    end

    return_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (push),
        .pop       (pop),
        .push_data (PC_PLUS4),
        .top       (ras_top),
        .empty     (RAS_EMPTY),
        .full      (RAS_FULL),
        .overflow  (RAS_OVF),
        .underflow (RAS_UNF)
    );
endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: vector table, corner sequences, random vs model.
module tb_next_pc_unit;
    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic [2:0]  BR_MODE;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic [31:0] TARGET;
    logic        RAS_EMPTY;
    logic        RAS_FULL;
    logic        RAS_OVF;
    logic        RAS_UNF;

    next_pc_unit #(
        .PC_W(32), .OFF_W(8), .RAS_DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .BR_MODE(BR_MODE),
        .ZERO(ZERO), .OFFSET(OFFSET), .PC(PC), .PC_PLUS4(PC_PLUS4),
        .TARGET(TARGET), .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL),
        .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] ras[$];
    logic        m_ovf;
    logic        m_unf;

    typedef struct {
        logic [2:0]  mode;
        logic        z;
        logic [7:0]  off;
        logic        st;
        logic [31:0] pc;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] sext(input logic [7:0] o);
        return {{24{o[7]}}, o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] md, input logic z,
                              input logic [7:0] off, input logic st);
        logic [31:0] t;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (st) return;
        t = m_pc + 32'd4 + (sext(off) << 2);
        case (md)
            3'd1: m_pc = t;
            3'd2: m_pc = z ? t : m_pc + 32'd4;
            3'd3: m_pc = z ? m_pc + 32'd4 : t;
            3'd4: begin
                if (ras.size() == 4) begin
                    void'(ras.pop_front());
                    m_ovf = 1'b1;
                end
                ras.push_back(m_pc + 32'd4);
                m_pc = t;
            end
            3'd5: begin
                if (ras.size() == 0) begin
                    m_unf = 1'b1;
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_pc = ras.pop_back();
                end
            end
            default: m_pc = m_pc + 32'd4;
        endcase
    endtask

    task automatic model_chk(input int n);
        chk($sformatf("rnd%0d pc", n), PC, m_pc);
        chk($sformatf("rnd%0d empty", n), {31'b0, RAS_EMPTY},
            {31'b0, ras.size() == 0});
        chk($sformatf("rnd%0d full", n), {31'b0, RAS_FULL},
            {31'b0, ras.size() == 4});
        chk($sformatf("rnd%0d ovf", n), {31'b0, RAS_OVF}, {31'b0, m_ovf});
        chk($sformatf("rnd%0d unf", n), {31'b0, RAS_UNF}, {31'b0, m_unf});
    endtask

    task automatic cycle(input logic [2:0] md, input logic z,
                         input logic [7:0] off, input logic st);
        @(negedge CLK);
        BR_MODE = md;
        ZERO    = z;
        OFFSET  = off;
        STALL   = st;
        #1;
        chk("pc_plus4", PC_PLUS4, m_pc + 32'd4);
        chk("target", TARGET, m_pc + 32'd4 + (sext(off) << 2));
        @(posedge CLK);
        #1;
        model_step(md, z, off, st);
    endtask

    task automatic do_reset(input string nm);
        @(negedge CLK);
        STALL = 1'b1;
        #2 RESET = 1'b0;
        #1;
        chk({nm, " pc"}, PC, 32'h0);
        chk({nm, " empty"}, {31'b0, RAS_EMPTY}, 32'd1);
        chk({nm, " full"}, {31'b0, RAS_FULL}, 32'd0);
        chk({nm, " ovf"}, {31'b0, RAS_OVF}, 32'd0);
        chk({nm, " unf"}, {31'b0, RAS_UNF}, 32'd0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        RESET   = 1'b0;
        STALL   = 1'b1;
        BR_MODE = 3'd0;
        ZERO    = 1'b0;
        OFFSET  = 8'h0;
        model_reset();

        tbl[0]  = '{3'd0, 1'b0, 8'h00, 1'b0, 32'h04, 1, 0, 0, 0};
        tbl[1]  = '{3'd0, 1'b0, 8'h00, 1'b0, 32'h08, 1, 0, 0, 0};
        tbl[2]  = '{3'd0, 1'b0, 8'h00, 1'b0, 32'h0C, 1, 0, 0, 0};
        tbl[3]  = '{3'd1, 1'b0, 8'h0C, 1'b0, 32'h40, 1, 0, 0, 0};
        tbl[4]  = '{3'd2, 1'b1, 8'hFE, 1'b0, 32'h3C, 1, 0, 0, 0};
        tbl[5]  = '{3'd1, 1'b0, 8'h00, 1'b0, 32'h40, 1, 0, 0, 0};
        tbl[6]  = '{3'd2, 1'b0, 8'hFE, 1'b0, 32'h44, 1, 0, 0, 0};
        tbl[7]  = '{3'd1, 1'b0, 8'hFE, 1'b0, 32'h40, 1, 0, 0, 0};
        tbl[8]  = '{3'd3, 1'b0, 8'hFE, 1'b0, 32'h3C, 1, 0, 0, 0};
        tbl[9]  = '{3'd1, 1'b0, 8'h00, 1'b0, 32'h40, 1, 0, 0, 0};
        tbl[10] = '{3'd3, 1'b1, 8'hFE, 1'b0, 32'h44, 1, 0, 0, 0};
        tbl[11] = '{3'd1, 1'b0, 8'hF2, 1'b0, 32'h10, 1, 0, 0, 0};
        tbl[12] = '{3'd4, 1'b0, 8'h04, 1'b0, 32'h24, 0, 0, 0, 0};
        tbl[13] = '{3'd5, 1'b0, 8'h00, 1'b1, 32'h24, 0, 0, 0, 0};
        tbl[14] = '{3'd5, 1'b0, 8'h00, 1'b0, 32'h14, 1, 0, 0, 0};
        tbl[15] = '{3'd5, 1'b0, 8'h00, 1'b0, 32'h18, 1, 0, 0, 1};
        tbl[16] = '{3'd4, 1'b0, 8'h04, 1'b1, 32'h18, 1, 0, 0, 0};
        tbl[17] = '{3'd7, 1'b1, 8'h55, 1'b0, 32'h1C, 1, 0, 0, 0};

        repeat (2) @(posedge CLK);
        #1;
        chk("reset pc", PC, 32'h0);
        chk("reset empty", {31'b0, RAS_EMPTY}, 32'd1);
        chk("reset full", {31'b0, RAS_FULL}, 32'd0);
        chk("reset ovf", {31'b0, RAS_OVF}, 32'd0);
        chk("reset unf", {31'b0, RAS_UNF}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].mode, tbl[i].z, tbl[i].off, tbl[i].st);
            chk($sformatf("row%0d pc", i), PC, tbl[i].pc);
            chk($sformatf("row%0d empty", i), {31'b0, RAS_EMPTY},
                {31'b0, tbl[i].emp});
            chk($sformatf("row%0d full", i), {31'b0, RAS_FULL},
                {31'b0, tbl[i].ful});
            chk($sformatf("row%0d ovf", i), {31'b0, RAS_OVF},
                {31'b0, tbl[i].ovf});
            chk($sformatf("row%0d unf", i), {31'b0, RAS_UNF},
                {31'b0, tbl[i].unf});
        end

        do_reset("rst_a");
        for (int k = 1; k <= 5; k++) begin
            cycle(3'd4, 1'b0, 8'h00, 1'b0);
            chk($sformatf("call%0d pc", k), PC, 32'(4 * k));
            chk($sformatf("call%0d ovf", k), {31'b0, RAS_OVF},
                {31'b0, k == 5});
            chk($sformatf("call%0d full", k), {31'b0, RAS_FULL},
                {31'b0, k >= 4});
            if (k == 4) begin
                cycle(3'd4, 1'b0, 8'h00, 1'b1);
                chk("stall full pc", PC, 32'd16);
                chk("stall full ovf", {31'b0, RAS_OVF}, 32'd0);
            end
        end
        begin
            logic [31:0] ret_exp [5];
            ret_exp = '{32'd20, 32'd16, 32'd12, 32'd8, 32'd12};
            for (int k = 0; k < 5; k++) begin
                cycle(3'd5, 1'b0, 8'h00, 1'b0);
                chk($sformatf("ret%0d pc", k), PC, ret_exp[k]);
                chk($sformatf("ret%0d unf", k), {31'b0, RAS_UNF},
                    {31'b0, k == 4});
            end
        end
        chk("ret empty", {31'b0, RAS_EMPTY}, 32'd1);

        do_reset("rst_b");
        cycle(3'd4, 1'b0, 8'h08, 1'b0);
        cycle(3'd4, 1'b0, 8'h08, 1'b0);
        chk("two calls empty", {31'b0, RAS_EMPTY}, 32'd0);
        do_reset("rst_mid");

        cycle(3'd1, 1'b0, 8'hFE, 1'b0);
        chk("wrap pre pc", PC, 32'hFFFF_FFFC);
        cycle(3'd0, 1'b0, 8'h00, 1'b0);
        chk("wrap pc", PC, 32'h0);

        do_reset("rst_c");
        for (int n = 0; n < 600; n++) begin
            logic [2:0] md;
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      md = 3'd4;
            else if (r < 6) md = 3'd5;
            else            md = 3'($urandom_range(0, 7));
            cycle(md, 1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 7) == 0));
            model_chk(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
